alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle 8x8 -> 16-bit unsigned multiplier sequencer that drives the shared 8-bit ALU as its initiator. It issues ADD, shift-right and OR operations on the ALU's operand/op ports one per cycle and captures the ALU result and status flags on each clock edge. It implements shift-and-add multiply with fixed, data-independent latency. It sits beside the CPU datapath and owns the ALU ports only while `busy_out` is high.

## Interface
- No parameters. The 8-bit datapath is fixed by the ALU op set.

- `clk_in`  in  1  clock; all state changes on the rising edge.
- `rst_in`  in  1  reset, synchronous and active-high.
- `start_in`  in  1  request a multiply; sampled only in IDLE.
- `a_in`  in  8  multiplicand, captured on the accept edge.
- `b_in`  in  8  multiplier, captured on the accept edge.
- `busy_out`  out  1  high whenever state != IDLE.
- `valid_out`  out  1  one-cycle pulse, high in DONE.
- `product_out`  out  16  `{P_H, P_L}` registers; holds its value until the next accept.
- `zero_out`  out  1  registered on entry to DONE: 1 when the product is 0; holds.
- `alu_a_out`  out  8  ALU operand A (combinational from state and registers).
- `alu_b_out`  out  8  ALU operand B.
- `alu_op_out`  out  4  ALU op: 0x0 SLR, 0x6 ADD, 0xA OR, 0xB MOV.
- `alu_status_out`  out  4  status fed to the ALU; constant 4'h0.
- `alu_result_in`  in  8  ALU result.
- `alu_status_in`  in  4  ALU flags `{C,S,V,Z}`, bit 3 = carry.

## Operation
- **Registers:** M (multiplicand), P_H, P_L, iteration counter `it[2:0]`, c_reg, lsb_reg.
- **States:** IDLE, ADD, SHR_H, FIX_H, SHR_L, FIX_L, DONE.
- **IDLE**
  - ALU outputs: op=0xB, a=0, b=0.
  - On `start_in`: M<=a_in, P_L<=b_in, P_H<=0, it<=0, go to ADD.
- **ADD:** op=0x6, a=P_H, b=(P_L[0] ? M : 8'h00).
  - Capture P_H<=result, c_reg<=status[3].
- **SHR_H:** op=0x0, a=P_H, b=0.
  - Capture P_H<=result, lsb_reg<=status[3] (the bit shifted out).
- **FIX_H:** op=0xA, a=P_H, b=(c_reg ? 8'h80 : 8'h00).
  - Capture P_H<=result.
- **SHR_L:** op=0x0, a=P_L.
  - Capture P_L<=result.
- **FIX_L:** op=0xA, a=P_L, b=(lsb_reg ? 8'h80 : 8'h00).
  - Capture P_L<=result.
  - If it==7, go to DONE; else it<=it+1 and go to ADD.
- **Net effect per iteration:** `{c,P_H,P_L} = ({P_H + (bit ? M : 0)}, P_L) >> 1`.
- **DONE:** ALU outputs as in IDLE, `valid_out`=1, then go to IDLE.
  - `zero_out` is registered as `(P_H|P_L)==0` on the transition into DONE.
- **Widths:** ADD is a pure 8-bit add with no carry-in, so the carry is carried only via c_reg. The counter wraps 7->0 but is never used past 7.
- **Port ownership:** all `alu_*` outputs are combinational from state and registers. The ALU result is used only at the edge that ends each ALU state.

## Timing
- **Accept edge t0:** an edge where state=IDLE and `start_in`=1.
- **ALU states** occupy cycles 1..40 after t0: 5 per iteration x 8 iterations.
- **DONE** occupies cycle 41: `valid_out`=1 and `product_out` is final.
- **IDLE** resumes at cycle 42. The next accept can occur at the edge ending cycle 42, giving a throughput of 1 multiply per 42 cycles.
- **`busy_out`** is high in cycles 1..41.
- **`start_in` while busy (including DONE):** ignored, with no queueing. `a_in`/`b_in` are not sampled.
- **`product_out`:** intermediate values are visible during busy and must be treated as valid only when `valid_out`=1. The value holds through IDLE until the next accept edge.
- **Reset (any state, including mid-operation):** state<=IDLE, and P_H, P_L, M, it, c_reg, lsb_reg, `zero_out` <=0.
  - Outputs after reset: `busy_out`=0, `valid_out`=0, `product_out`=0, `zero_out`=0.
  - ALU outputs after reset: op=0xB, a=0, b=0; `alu_status_out`=0.
- **`rst_in` and `start_in` in the same cycle:** reset wins, and nothing is accepted.

## Test plan
- **0x0C x 0x0A:** start at t0 -> `valid_out` pulses in cycle 41 only; product_out=0x0078, zero_out=0, busy_out high cycles 1..41.
- **0xFF x 0xFF:** -> product_out=0xFE01 at cycle 41; this exercises c_reg=1 on FIX_H and lsb_reg=1 on FIX_L.
- **0x00 x 0x37:** -> product_out=0x0000, zero_out=1. Then **0x01 x 0x80** -> 0x0080, zero_out=0.
- **ALU op trace for 0x05 x 0x03:**
  - Cycle 1: op=6, a=0x00, b=0x05.
  - Cycle 2: op=0, a=0x05.
  - Cycle 3: op=A, b=0x00.
  - Cycle 4: op=0, a=0x03.
  - Cycle 5: op=A, b=0x80.
  - Final product_out=0x000F.
- **Start while busy:** pulse start_in with a=0x11, b=0x11 at cycles 10 and 41 of a 0x0C x 0x0A job -> result is still 0x0078, and no second job starts until a start in IDLE.
- **Reset mid-operation:** assert rst_in in cycle 20 -> next cycle busy_out=0, product_out=0, zero_out=0, alu_op_out=0xB. A following 0x07 x 0x09 then yields 0x003F at cycle 41.

Source files
------------

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 8x8 -> 16-bit unsigned shift-and-add multiplier that borrows
// the shared 8-bit ALU. Each iteration is five ALU steps: add, shift the high
// byte, repair its MSB from the add carry, shift the low byte, repair its MSB
// from the bit that fell out of the high byte. Latency is fixed at 41 cycles
// of busy time, independent of the operands.
module alu_mul_seq (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [7:0]  a_in,
    input  logic [7:0]  b_in,
    output logic        busy_out,
    output logic        valid_out,
    output logic [15:0] product_out,
    output logic        zero_out,
    output logic [7:0]  alu_a_out,
    output logic [7:0]  alu_b_out,
    output logic [3:0]  alu_op_out,
    output logic [3:0]  alu_status_out,
    input  logic [7:0]  alu_result_in,
    input  logic [3:0]  alu_status_in
);

    localparam logic [3:0] OpSlr = 4'h0;
    localparam logic [3:0] OpAdd = 4'h6;
    localparam logic [3:0] OpOr  = 4'hA;
    localparam logic [3:0] OpMov = 4'hB;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADD   = 3'd1,
        SHR_H = 3'd2,
        FIX_H = 3'd3,
        SHR_L = 3'd4,
        FIX_L = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  mult_q, mult_d;
    logic [7:0]  pHi_q, pHi_d;
    logic [7:0]  pLo_q, pLo_d;
    logic [2:0]  it_q, it_d;
    logic        carry_q, carry_d;
    logic        lsb_q, lsb_d;
    logic        zero_q, zero_d;

    // Only the carry flag of the ALU status is meaningful to this sequencer.
    logic        unusedFlags;
    assign unusedFlags = ^alu_status_in[2:0];

    assign busy_out       = (state_q != IDLE);
    assign valid_out      = (state_q == DONE);
    assign product_out    = {pHi_q, pLo_q};
    assign zero_out       = zero_q;
    assign alu_status_out = 4'h0;

    // Next-state logic and ALU drive: each ALU state presents its operands and
    // captures the result at the edge that leaves the state.
    always_comb begin
        state_d    = state_q;
        mult_d     = mult_q;
        pHi_d      = pHi_q;
        pLo_d      = pLo_q;
        it_d       = it_q;
        carry_d    = carry_q;
        lsb_d      = lsb_q;
        zero_d     = zero_q;
        alu_op_out = OpMov;
        alu_a_out  = 8'h00;
        alu_b_out  = 8'h00;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    mult_d  = a_in;
                    pLo_d   = b_in;
                    pHi_d   = 8'h00;
                    it_d    = 3'd0;
                    state_d = ADD;
                end
            end
            ADD: begin
                alu_op_out = OpAdd;
                alu_a_out  = pHi_q;
                alu_b_out  = pLo_q[0] ? mult_q : 8'h00;
                pHi_d      = alu_result_in;
                carry_d    = alu_status_in[3];
                state_d    = SHR_H;
            end
            SHR_H: begin
                alu_op_out = OpSlr;
                alu_a_out  = pHi_q;
                pHi_d      = alu_result_in;
                lsb_d      = alu_status_in[3];
                state_d    = FIX_H;
            end
            FIX_H: begin
                alu_op_out = OpOr;
                alu_a_out  = pHi_q;
                alu_b_out  = carry_q ? 8'h80 : 8'h00;
                pHi_d      = alu_result_in;
                state_d    = SHR_L;
            end
            SHR_L: begin
                alu_op_out = OpSlr;
                alu_a_out  = pLo_q;
                pLo_d      = alu_result_in;
                state_d    = FIX_L;
            end
            FIX_L: begin
                alu_op_out = OpOr;
                alu_a_out  = pLo_q;
                alu_b_out  = lsb_q ? 8'h80 : 8'h00;
                pLo_d      = alu_result_in;
                if (it_q == 3'd7) begin
                    zero_d  = ((pHi_q | alu_result_in) == 8'h00);
                    state_d = DONE;
                end else begin
                    it_d    = it_q + 3'd1;
                    state_d = ADD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset overrides any pending accept.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            mult_q  <= 8'h00;
            pHi_q   <= 8'h00;
            pLo_q   <= 8'h00;
            it_q    <= 3'd0;
            carry_q <= 1'b0;
            lsb_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mult_q  <= mult_d;
            pHi_q   <= pHi_d;
            pLo_q   <= pLo_d;
            it_q    <= it_d;
            carry_q <= carry_d;
            lsb_q   <= lsb_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq: provides a behavioural ALU, runs multiply jobs
// and compares results from a scoreboard queue filled at each accept.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        busy_out;
    logic        valid_out;
    logic [15:0] product_out;
    logic        zero_out;
    logic [7:0]  alu_a_out;
    logic [7:0]  alu_b_out;
    logic [3:0]  alu_op_out;
    logic [3:0]  alu_status_out;
    logic [7:0]  alu_result_in;
    logic [3:0]  alu_status_in;

    int testsRun    = 0;
    int testsFailed = 0;

    // Each entry is {expected zero flag, expected product}.
    logic [16:0] expQ[$];

    alu_mul_seq dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .a_in           (a_in),
        .b_in           (b_in),
        .busy_out       (busy_out),
        .valid_out      (valid_out),
        .product_out    (product_out),
        .zero_out       (zero_out),
        .alu_a_out      (alu_a_out),
        .alu_b_out      (alu_b_out),
        .alu_op_out     (alu_op_out),
        .alu_status_out (alu_status_out),
        .alu_result_in  (alu_result_in),
        .alu_status_in  (alu_status_in)
    );

    always #5 clk = ~clk;

    // Behavioural model of the shared ALU, flags packed as {C,S,V,Z}.
    logic [7:0] aluRes;
    logic       aluC;
    always_comb begin
        aluRes = 8'h00;
        aluC   = 1'b0;
        case (alu_op_out)
            4'h0: begin
                aluRes = alu_a_out >> 1;
                aluC   = alu_a_out[0];
            end
            4'h6: {aluC, aluRes} = {1'b0, alu_a_out} + {1'b0, alu_b_out};
            4'hA: aluRes = alu_a_out | alu_b_out;
            4'hB: aluRes = alu_b_out;
            default: aluRes = 8'h00;
        endcase
        alu_result_in = aluRes;
        alu_status_in = {aluC, aluRes[7], 1'b0, (aluRes == 8'h00)};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one job at the next edge and checks it cycle by cycle.
    // mode 0: plain, 1: start pulses while busy, 2: ALU trace for 0x05 x 0x03.
    task automatic run_job(input logic [7:0] a, input logic [7:0] b, input int mode);
        logic [15:0] prod;
        logic [16:0] exp;
        logic [7:0]  trOp[1:5];
        logic [7:0]  trA[1:5];
        logic [7:0]  trB[1:5];
        int          validCount;
        int          validCycle;
        prod = 16'(a) * 16'(b);
        trOp = '{8'h06, 8'h00, 8'h0A, 8'h00, 8'h0A};
        trA  = '{8'h00, 8'h05, 8'h02, 8'h03, 8'h01};
        trB  = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h80};
        validCount = 0;
        validCycle = 0;
        expQ.push_back({(prod == 16'h0000), prod});
        a_in = a;
        b_in = b;
        start_in = 1'b1;
        tick();
        for (int k = 1; k <= 45; k++) begin
            if (mode == 1 && (k == 10 || k == 41)) begin
                start_in = 1'b1;
                a_in = 8'h11;
                b_in = 8'h11;
            end else begin
                start_in = 1'b0;
                a_in = 8'($urandom);
                b_in = 8'($urandom);
            end
            testsRun++;
            if (busy_out !== (k <= 41)) begin
                testsFailed++;
                $display("[TB] FAIL busy cycle %0d: got %b want %b", k, busy_out, (k <= 41));
            end
            if (mode == 2 && k <= 5) begin
                testsRun++;
                if (alu_op_out !== trOp[k][3:0]) begin
                    testsFailed++;
                    $display("[TB] FAIL trace op cycle %0d: got %h want %h", k, alu_op_out, trOp[k][3:0]);
                end
                testsRun++;
                if (alu_a_out !== trA[k]) begin
                    testsFailed++;
                    $display("[TB] FAIL trace a cycle %0d: got %h want %h", k, alu_a_out, trA[k]);
                end
                if (k != 4) begin
                    testsRun++;
                    if (alu_b_out !== trB[k]) begin
                        testsFailed++;
                        $display("[TB] FAIL trace b cycle %0d: got %h want %h", k, alu_b_out, trB[k]);
                    end
                end
            end
            if (valid_out === 1'b1) begin
                validCount++;
                validCycle = k;
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected valid cycle %0d: got 1 want 0", k);
                end else begin
                    exp = expQ.pop_front();
                    testsRun++;
                    if (product_out !== exp[15:0]) begin
                        testsFailed++;
                        $display("[TB] FAIL product %h*%h: got %h want %h", a, b, product_out, exp[15:0]);
                    end
                    testsRun++;
                    if (zero_out !== exp[16]) begin
                        testsFailed++;
                        $display("[TB] FAIL zero %h*%h: got %b want %b", a, b, zero_out, exp[16]);
                    end
                end
            end
            if (k == 45) begin
                testsRun++;
                if (product_out !== prod) begin
                    testsFailed++;
                    $display("[TB] FAIL product hold: got %h want %h", product_out, prod);
                end
            end
            tick();
        end
        start_in = 1'b0;
        testsRun++;
        if (validCount != 1 || validCycle != 41) begin
            testsFailed++;
            $display("[TB] FAIL valid timing: got %0d pulses last at %0d want 1 at 41", validCount, validCycle);
        end
        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL result timeout: got %0d pending want 0", expQ.size());
            expQ.delete();
        end
    endtask

    // Idle outputs after reset, and reset beating a simultaneous start.
    task automatic test_reset();
        testsRun++;
        if (busy_out !== 1'b0 || valid_out !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset busy/valid: got %b%b want 00", busy_out, valid_out);
        end
        testsRun++;
        if (product_out !== 16'h0000 || zero_out !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset product/zero: got %h/%b want 0000/0", product_out, zero_out);
        end
        testsRun++;
        if (alu_op_out !== 4'hB || alu_a_out !== 8'h00 || alu_b_out !== 8'h00 || alu_status_out !== 4'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset alu: got op %h a %h b %h st %h want b/00/00/0",
                     alu_op_out, alu_a_out, alu_b_out, alu_status_out);
        end
        rst_in = 1'b1;
        start_in = 1'b1;
        a_in = 8'h03;
        b_in = 8'h03;
        tick();
        rst_in = 1'b0;
        start_in = 1'b0;
        testsRun++;
        if (busy_out !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset vs start: got busy %b want 0", busy_out);
        end
        tick();
    endtask

    task automatic test_basic();
        run_job(8'h0C, 8'h0A, 0);
        run_job(8'hFF, 8'hFF, 0);
    endtask

    task automatic test_zero();
        run_job(8'h00, 8'h37, 0);
        run_job(8'h01, 8'h80, 0);
    endtask

    task automatic test_alu_trace();
        run_job(8'h05, 8'h03, 2);
    endtask

    task automatic test_start_while_busy();
        run_job(8'h0C, 8'h0A, 1);
    endtask

    // Reset in cycle 20 of a job, after a zero-result job left zero_out set.
    task automatic test_reset_mid();
        run_job(8'h00, 8'h37, 0);
        a_in = 8'h0C;
        b_in = 8'h0A;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int k = 1; k < 20; k++) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        testsRun++;
        if (busy_out !== 1'b0 || valid_out !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid reset busy/valid: got %b%b want 00", busy_out, valid_out);
        end
        testsRun++;
        if (product_out !== 16'h0000 || zero_out !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid reset product/zero: got %h/%b want 0000/0", product_out, zero_out);
        end
        testsRun++;
        if (alu_op_out !== 4'hB || alu_a_out !== 8'h00 || alu_b_out !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL mid reset alu: got op %h a %h b %h want b/00/00", alu_op_out, alu_a_out, alu_b_out);
        end
        run_job(8'h07, 8'h09, 0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            run_job(8'($urandom), 8'($urandom), 0);
        end
    endtask

    // Top-level sequence of scenarios.
    initial begin
        rst_in = 1'b1;
        start_in = 1'b0;
        a_in = 8'h00;
        b_in = 8'h00;
        tick();
        tick();
        rst_in = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_alu_trace();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
